// File: rtl/st506_seek_controller.sv
// ST-506 head positioning sequencer: accepts seek/recalibrate commands, issues one
// step at a time to the step generator, tracks the cylinder and waits for seek complete.
module st506_seek_controller #(
    parameter int CYL_W       = 11,
    parameter int MAX_CYL     = 1023,
    parameter int RECAL_LIMIT = 1100,
    parameter int TMO_W       = 24
) (
    input  logic             clk,
    input  logic             reset_n,
    // Command handshake: a command is taken on any cycle with cmd_valid && cmd_ready.
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_recal,
    input  logic [CYL_W-1:0] cmd_cylinder,
    input  logic [TMO_W-1:0] settle_timeout,
    output logic             step_request,
    output logic             step_direction,
    input  logic             step_done,
    input  logic             seek_complete,
    input  logic             at_track00,
    input  logic             drive_ready,
    output logic [CYL_W-1:0] current_cyl,
    output logic             pos_valid,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [2:0]       err_code,
    output logic [2:0]       dbg_state
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHECK     = 3'd1,
        STEP_REQ  = 3'd2,
        STEP_WAIT = 3'd3,
        SETTLE    = 3'd4
    } state_t;

    localparam int SC_W = $clog2(RECAL_LIMIT + 1);
    localparam logic [CYL_W-1:0] MAX_CYL_C     = CYL_W'(MAX_CYL);
    localparam logic [SC_W-1:0]  RECAL_LIMIT_C = SC_W'(RECAL_LIMIT);

    localparam logic [2:0] ERR_NOT_READY  = 3'd1;
    localparam logic [2:0] ERR_RECAL_FAIL = 3'd2;
    localparam logic [2:0] ERR_TIMEOUT    = 3'd3;
    localparam logic [2:0] ERR_RANGE      = 3'd4;
    localparam logic [2:0] ERR_NOT_CAL    = 3'd5;

    state_t           state_q, state_d;
    logic             recal_q, recal_d;
    logic [CYL_W-1:0] target_q, target_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [TMO_W-1:0] timer_q, timer_d;
    logic [SC_W-1:0]  step_cnt_q, step_cnt_d;
    logic             dir_q, dir_d;
    logic [CYL_W-1:0] cyl_q, cyl_d;
    logic             pos_valid_q, pos_valid_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    logic [2:0]       err_code_q, err_code_d;
    logic             fail;
    logic [2:0]       fail_code;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            recal_q     <= 1'b0;
            target_q    <= '0;
            tmo_q       <= '0;
            timer_q     <= '0;
            step_cnt_q  <= '0;
            dir_q       <= 1'b0;
            cyl_q       <= '0;
            pos_valid_q <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            err_code_q  <= 3'd0;
        end else begin
            state_q     <= state_d;
            recal_q     <= recal_d;
            target_q    <= target_d;
            tmo_q       <= tmo_d;
            timer_q     <= timer_d;
            step_cnt_q  <= step_cnt_d;
            dir_q       <= dir_d;
            cyl_q       <= cyl_d;
            pos_valid_q <= pos_valid_d;
            done_q      <= done_d;
            error_q     <= error_d;
            err_code_q  <= err_code_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        recal_d     = recal_q;
        target_d    = target_q;
        tmo_d       = tmo_q;
        timer_d     = timer_q;
        step_cnt_d  = step_cnt_q;
        dir_d       = dir_q;
        cyl_d       = cyl_q;
        pos_valid_d = pos_valid_q;
        done_d      = 1'b0;
        error_d     = 1'b0;
        err_code_d  = err_code_q;
        fail        = 1'b0;
        fail_code   = 3'd0;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    recal_d    = cmd_recal;
                    target_d   = cmd_cylinder;
                    tmo_d      = settle_timeout;
                    err_code_d = 3'd0;
                    step_cnt_d = '0;
                    state_d    = CHECK;
                end
            end
            CHECK: begin
                if (!drive_ready) begin
                    fail      = 1'b1;
                    fail_code = ERR_NOT_READY;
                end else if (recal_q) begin
                    if (at_track00) begin
                        cyl_d       = '0;
                        pos_valid_d = 1'b1;
                        timer_d     = tmo_q;
                        state_d     = SETTLE;
                    end else if (step_cnt_q == RECAL_LIMIT_C) begin
                        fail      = 1'b1;
                        fail_code = ERR_RECAL_FAIL;
                    end else begin
                        dir_d   = 1'b0;
                        state_d = STEP_REQ;
                    end
                end else if (!pos_valid_q) begin
                    fail      = 1'b1;
                    fail_code = ERR_NOT_CAL;
                end else if (target_q > MAX_CYL_C) begin
                    fail      = 1'b1;
                    fail_code = ERR_RANGE;
                end else if (target_q == cyl_q) begin
                    timer_d = tmo_q;
                    state_d = SETTLE;
                end else begin
                    dir_d   = (target_q > cyl_q);
                    state_d = STEP_REQ;
                end
            end
            STEP_REQ: begin
                step_cnt_d = step_cnt_q + SC_W'(1);
                state_d    = STEP_WAIT;
            end
            STEP_WAIT: begin
                // Recalibrate steps do not move the tracked position; track00 defines it.
                if (step_done) begin
                    if (!recal_q) begin
                        cyl_d = dir_q ? cyl_q + CYL_W'(1) : cyl_q - CYL_W'(1);
                    end
                    state_d = CHECK;
                end
            end
            SETTLE: begin
                if (seek_complete) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (!drive_ready) begin
                    fail      = 1'b1;
                    fail_code = ERR_NOT_READY;
                end else if (timer_q == '0) begin
                    fail      = 1'b1;
                    fail_code = ERR_TIMEOUT;
                end else begin
                    timer_d = timer_q - TMO_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (fail) begin
            error_d    = 1'b1;
            err_code_d = fail_code;
            state_d    = IDLE;
            if (fail_code == ERR_NOT_READY || fail_code == ERR_RECAL_FAIL ||
                fail_code == ERR_TIMEOUT) begin
                pos_valid_d = 1'b0;
            end
        end
    end

    assign cmd_ready      = (state_q == IDLE);
    assign busy           = (state_q != IDLE);
    assign step_request   = (state_q == STEP_REQ);
    assign step_direction = dir_q;
    assign current_cyl    = cyl_q;
    assign pos_valid      = pos_valid_q;
    assign done           = done_q;
    assign error          = error_q;
    assign err_code       = err_code_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_st506_seek_controller.sv
// Directed bench for st506_seek_controller with a small drive model that answers
// each step request with a step_done pulse and moves a modelled head.
module tb_st506_seek_controller;

    localparam int CYL_W = 11;
    localparam int TMO_W = 24;

    logic             clk;
    logic             reset_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_recal;
    logic [CYL_W-1:0] cmd_cylinder;
    logic [TMO_W-1:0] settle_timeout;
    logic             step_request;
    logic             step_direction;
    logic             step_done;
    logic             seek_complete;
    logic             at_track00;
    logic             drive_ready;
    logic [CYL_W-1:0] current_cyl;
    logic             pos_valid;
    logic             busy;
    logic             done;
    logic             error;
    logic [2:0]       err_code;
    logic [2:0]       dbg_state;

    int checks = 0;
    int errors = 0;
    int pulse_cnt = 0;
    int in_cnt = 0;
    int mcyl = 0;
    logic no_trk0 = 1'b0;
    int cyc;

    st506_seek_controller #(
        .CYL_W(CYL_W), .MAX_CYL(1023), .RECAL_LIMIT(8), .TMO_W(TMO_W)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_recal(cmd_recal),
        .cmd_cylinder(cmd_cylinder), .settle_timeout(settle_timeout),
        .step_request(step_request), .step_direction(step_direction),
        .step_done(step_done), .seek_complete(seek_complete),
        .at_track00(at_track00), .drive_ready(drive_ready),
        .current_cyl(current_cyl), .pos_valid(pos_valid), .busy(busy),
        .done(done), .error(error), .err_code(err_code), .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign at_track00 = (mcyl == 0) && !no_trk0;

    // Drive model: step_done two negedges after a request is seen, head moves with it.
    initial begin
        logic d;
        step_done = 1'b0;
        forever begin
            @(negedge clk);
            if (step_request) begin
                pulse_cnt++;
                d = step_direction;
                if (d) in_cnt++;
                @(negedge clk);
                @(negedge clk);
                step_done = 1'b1;
                if (d) mcyl++;
                else if (mcyl > 0) mcyl--;
                @(negedge clk);
                step_done = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Presents a command for one cycle; returns at the first negedge after acceptance.
    task automatic send_cmd(input logic recal, input int cyl, input int tmo);
        @(negedge clk);
        check("cmd_ready_before_cmd", cmd_ready, 1);
        cmd_valid      = 1'b1;
        cmd_recal      = recal;
        cmd_cylinder   = CYL_W'(cyl);
        settle_timeout = TMO_W'(tmo);
        pulse_cnt      = 0;
        in_cnt         = 0;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Counts negedges since acceptance (the first one is 1) until done or error.
    task automatic wait_end(input int max_cyc, output int n);
        n = 1;
        while (!(done || error) && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        if (!(done || error)) check("completion_timeout", 0, 1);
    endtask

    initial begin
        reset_n        = 1'b0;
        cmd_valid      = 1'b0;
        cmd_recal      = 1'b0;
        cmd_cylinder   = '0;
        settle_timeout = '0;
        seek_complete  = 1'b1;
        drive_ready    = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);

        // Reset values
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_step_request", step_request, 0);
        check("rst_step_direction", step_direction, 0);
        check("rst_current_cyl", current_cyl, 0);
        check("rst_pos_valid", pos_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_err_code", err_code, 0);
        reset_n = 1'b1;

        // Seek before calibration
        send_cmd(1'b0, 5, 20);
        wait_end(50, cyc);
        check("uncal_error", error, 1);
        check("uncal_err_code", err_code, 5);
        check("uncal_pulses", pulse_cnt, 0);
        check("uncal_cycles", cyc, 2);

        // Recalibrate from cylinder 4
        mcyl = 4;
        send_cmd(1'b1, 0, 20);
        wait_end(200, cyc);
        check("recal_done", done, 1);
        check("recal_pulses", pulse_cnt, 4);
        check("recal_in_pulses", in_cnt, 0);
        check("recal_cyl", current_cyl, 0);
        check("recal_pos_valid", pos_valid, 1);
        check("recal_err_code", err_code, 0);
        check("recal_cmd_ready_with_done", cmd_ready, 1);

        // Seek 0 -> 3 with accept latency checks
        send_cmd(1'b0, 3, 20);
        check("lat_busy_check", busy, 1);
        check("lat_no_req_in_check", step_request, 0);
        @(negedge clk);
        check("lat_req_at_n2", step_request, 1);
        check("lat_dir_in", step_direction, 1);
        wait_end(200, cyc);
        check("seek03_done", done, 1);
        check("seek03_pulses", pulse_cnt, 3);
        check("seek03_in_pulses", in_cnt, 3);
        check("seek03_cyl", current_cyl, 3);
        check("seek03_busy_low", busy, 0);

        // Seek 3 -> 1
        send_cmd(1'b0, 1, 20);
        wait_end(200, cyc);
        check("seek31_done", done, 1);
        check("seek31_pulses", pulse_cnt, 2);
        check("seek31_in_pulses", in_cnt, 0);
        check("seek31_cyl", current_cyl, 1);

        // Seek 1 -> 1: straight to settle
        send_cmd(1'b0, 1, 20);
        wait_end(50, cyc);
        check("seek11_done", done, 1);
        check("seek11_pulses", pulse_cnt, 0);
        check("seek11_cycles", cyc, 3);

        // Settle timeout of 10: eleven samples then error
        seek_complete = 1'b0;
        send_cmd(1'b0, 1, 10);
        wait_end(100, cyc);
        check("tmo_error", error, 1);
        check("tmo_err_code", err_code, 3);
        check("tmo_cycles", cyc, 13);
        check("tmo_pos_valid", pos_valid, 0);
        check("tmo_cyl_kept", current_cyl, 1);
        seek_complete = 1'b1;

        // Recalibrate that never finds track 0
        no_trk0 = 1'b1;
        mcyl = 20;
        send_cmd(1'b1, 0, 20);
        wait_end(300, cyc);
        check("rfail_error", error, 1);
        check("rfail_err_code", err_code, 2);
        check("rfail_pulses", pulse_cnt, 8);
        check("rfail_pos_valid", pos_valid, 0);
        no_trk0 = 1'b0;

        // Recalibrate from 2; err_code clears on acceptance
        mcyl = 2;
        send_cmd(1'b1, 0, 20);
        check("errcode_cleared", err_code, 0);
        wait_end(200, cyc);
        check("recal2_done", done, 1);
        check("recal2_pulses", pulse_cnt, 2);
        check("recal2_pos_valid", pos_valid, 1);

        // Out-of-range target
        send_cmd(1'b0, 1024, 20);
        wait_end(50, cyc);
        check("range_error", error, 1);
        check("range_err_code", err_code, 4);
        check("range_pulses", pulse_cnt, 0);
        check("range_pos_valid_kept", pos_valid, 1);

        // Reset while a seek is mid-flight (second step outstanding)
        send_cmd(1'b0, 3, 20);
        repeat (6) @(negedge clk);
        check("midrst_cyl_before", current_cyl, 1);
        reset_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_cmd_ready", cmd_ready, 1);
        check("midrst_cyl", current_cyl, 0);
        check("midrst_pos_valid", pos_valid, 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        check("midrst_stays_idle", busy, 0);
        check("midrst_pulses", pulse_cnt, 2);

        // Drive drops ready during settle
        mcyl = 0;
        seek_complete = 1'b0;
        send_cmd(1'b1, 0, 100);
        repeat (4) @(negedge clk);
        check("nrdy_pos_valid_set", pos_valid, 1);
        drive_ready = 1'b0;
        wait_end(50, cyc);
        check("nrdy_error", error, 1);
        check("nrdy_err_code", err_code, 1);
        check("nrdy_pos_valid", pos_valid, 0);
        drive_ready = 1'b1;
        seek_complete = 1'b1;

        @(negedge clk);
        check("final_error_single_cycle", error, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
